// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-check helpers for the LSU memory port.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FAULT    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width encodings; loads add the unsigned variants.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator: checks the request, drives one memory
// access cycle, captures load data and holds the response until consumed.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic        resp_is_store,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] DMEM_LAST = 32'(DMEM_BYTES - 1);

    state_t state;
    err_t   req_err;
    logic   accept;

    // Illegal outranks misaligned, which outranks the range fault.
    always_comb begin
        req_err = ERR_NONE;
        if (!is_legal_f3(req_we, req_funct3))
            req_err = ERR_ILLEGAL;
        else if (is_misaligned(req_funct3, req_addr[1:0]))
            req_err = ERR_MISALIGN;
        else if (req_addr > DMEM_LAST)
            req_err = ERR_FAULT;
    end

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // Strobes decode from state so an async reset drops them immediately.
    assign mem_read  = (state == ISSUE) && !resp_is_store;
    assign mem_write = (state == ISSUE) &&  resp_is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_funct3     <= '0;
            resp_rdata     <= '0;
            resp_rd        <= '0;
            resp_err       <= ERR_NONE;
            resp_is_store  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_address    <= req_addr;
                        mem_write_data <= req_wdata;
                        mem_funct3     <= req_funct3;
                        resp_rd        <= req_rd;
                        resp_is_store  <= req_we;
                        resp_err       <= req_err;
                        resp_rdata     <= '0;
                        state          <= (req_err == ERR_NONE) ? ISSUE : RESP;
                    end
                end
                ISSUE:   state <= resp_is_store ? RESP : CAPTURE;
                CAPTURE: begin
                    resp_rdata <= mem_read_data;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
